unified_mem_arbiter: RTL and testbench

//   Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage data access.

---
 rtl/unified_mem_arbiter_pkg.sv | 24 ++
 rtl/unified_mem_arbiter_lat_counter.sv | 36 +++
 rtl/unified_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings and grant helper for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Data wins contention unless fetch has been starved for the full window.
  function automatic arb_owner_e pick_owner(logic i_req, logic d_req, logic starved);
    if (i_req && (!d_req || starved)) begin
      return OWN_I;
    end else begin
      return OWN_D;
    end
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_lat_counter.sv
// Load/decrement down-counter that times one memory access and flags zero.
module arb_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// with fixed-length accesses, a one-cycle ready pulse and fetch starvation protection.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_MemRead,
  output logic          mem_MemWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          stall_fetch,
  output logic          stall_pipe
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e    state_q;
  arb_owner_e    owner_q;
  arb_owner_e    grant_own_s;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] i_rdata_q, d_rdata_q;
  logic          i_ready_q, d_ready_q;
  logic          rd_q, wr_q;
  logic [SW-1:0] starve_q;
  logic          req_any_s, load_s, dec_s, cnt_zero_s;

  assign req_any_s   = i_req | d_req;
  assign grant_own_s = pick_owner(i_req, d_req, starve_q == STARVE_LIM);
  assign load_s      = (state_q == ARB_IDLE) & req_any_s;
  assign dec_s       = (state_q == ARB_ACCESS) & ~cnt_zero_s;

  arb_lat_counter #(.W(CW)) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_s),
    .dec_i      (dec_s),
    .load_val_i (LAT_LOAD),
    .zero_o     (cnt_zero_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      starve_q  <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (!i_req) begin
            starve_q <= '0;
          end
          if (req_any_s) begin
            owner_q <= grant_own_s;
            state_q <= ARB_ACCESS;
            if (grant_own_s == OWN_D) begin
              addr_q <= d_addr;
              wd_q   <= d_wdata;
              we_q   <= d_we;
              rd_q   <= ~d_we;
              wr_q   <= d_we;
              if (i_req && (starve_q != STARVE_LIM)) begin
                starve_q <= starve_q + SW'(1);
              end
            end else begin
              addr_q   <= i_addr;
              we_q     <= 1'b0;
              rd_q     <= 1'b1;
              wr_q     <= 1'b0;
              starve_q <= '0;
            end
          end
        end
        ARB_ACCESS: begin
          if (cnt_zero_s) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= ARB_DONE;
            if (owner_q == OWN_D) begin
              d_ready_q <= 1'b1;
              if (!we_q) begin
                d_rdata_q <= mem_rd;
              end
            end else begin
              i_ready_q <= 1'b1;
              i_rdata_q <= mem_rd;
            end
          end
        end
        ARB_DONE: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_ready      = i_ready_q;
  assign d_ready      = d_ready_q;
  assign mem_MemRead  = rd_q;
  assign mem_MemWrite = wr_q;
  assign mem_addr     = addr_q;
  assign mem_wd       = wd_q;
  assign stall_fetch  = i_req & ~i_ready_q;
  assign stall_pipe   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed, cycle-exact checks of the unified memory arbiter with a small memory model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wd, mem_rd;
  logic        i_ready, d_ready, mem_MemRead, mem_MemWrite, stall_fetch, stall_pipe;
  logic [31:0] mem [0:255];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .stall_fetch(stall_fetch), .stall_pipe(stall_pipe)
  );

  assign mem_rd = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_MemWrite) mem[mem_addr[9:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h04] = 32'h8C01_0004;
    mem[8'h10] = 32'h1234_5678;
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h10; d_addr = 32'h40; d_wdata = 32'h0;

    // 1: reset with both requests high, then data granted first
    step(); step(); step();
    check("rst_i_ready", {31'b0, i_ready}, 32'd0);
    check("rst_d_ready", {31'b0, d_ready}, 32'd0);
    check("rst_rd", {31'b0, mem_MemRead}, 32'd0);
    check("rst_wr", {31'b0, mem_MemWrite}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b1;
    step();
    check("rst_first_grant_d", mem_addr, 32'h40);
    check("rst_first_rd", {31'b0, mem_MemRead}, 32'd1);
    step(); step();
    check("rst_first_d_ready", {31'b0, d_ready}, 32'd1);
    i_req = 1'b0; d_req = 1'b0;
    step();

    // 2: single fetch
    i_req = 1'b1; #1;
    check("f_stall_c0", {31'b0, stall_fetch}, 32'd1);
    step();
    check("f_rd_c1", {31'b0, mem_MemRead}, 32'd1);
    check("f_wr_c1", {31'b0, mem_MemWrite}, 32'd0);
    check("f_addr_c1", mem_addr, 32'h10);
    check("f_stall_c1", {31'b0, stall_fetch}, 32'd1);
    step();
    check("f_rd_c2", {31'b0, mem_MemRead}, 32'd1);
    check("f_ready_c2", {31'b0, i_ready}, 32'd0);
    check("f_stall_c2", {31'b0, stall_fetch}, 32'd1);
    step();
    check("f_ready_c3", {31'b0, i_ready}, 32'd1);
    check("f_rdata_c3", i_rdata, 32'h8C01_0004);
    check("f_rd_c3", {31'b0, mem_MemRead}, 32'd0);
    check("f_stall_c3", {31'b0, stall_fetch}, 32'd0);
    i_req = 1'b0;
    step();

    // 3: contention, data first then fetch
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    step(); step(); step();
    check("c_d_ready_c3", {31'b0, d_ready}, 32'd1);
    check("c_d_rdata_c3", d_rdata, 32'h1234_5678);
    check("c_i_ready_c3", {31'b0, i_ready}, 32'd0);
    d_req = 1'b0;
    step();
    check("c_idle_rd_c4", {31'b0, mem_MemRead}, 32'd0);
    step();
    check("c_i_addr_c5", mem_addr, 32'h10);
    step(); step();
    check("c_i_ready_c7", {31'b0, i_ready}, 32'd1);
    check("c_i_rdata_c7", i_rdata, 32'h8C01_0004);
    i_req = 1'b0;
    step();

    // 4: starvation: three data accesses, fourth grant is fetch, then data again
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("s_addr_%0d", k), mem_addr, (k == 3) ? 32'h10 : 32'h40);
      step(); step();
      check($sformatf("s_d_ready_%0d", k), {31'b0, d_ready}, (k == 3) ? 32'd0 : 32'd1);
      check($sformatf("s_i_ready_%0d", k), {31'b0, i_ready}, (k == 3) ? 32'd1 : 32'd0);
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    step(); step(); step(); step();

    // 5: store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; #1;
    check("st_stall_c0", {31'b0, stall_pipe}, 32'd1);
    step();
    check("st_wr_c1", {31'b0, mem_MemWrite}, 32'd1);
    check("st_rd_c1", {31'b0, mem_MemRead}, 32'd0);
    check("st_addr_c1", mem_addr, 32'h40);
    check("st_wd_c1", mem_wd, 32'hDEAD_BEEF);
    step();
    check("st_wr_c2", {31'b0, mem_MemWrite}, 32'd1);
    step();
    check("st_ready_c3", {31'b0, d_ready}, 32'd1);
    check("st_rdata_kept", d_rdata, 32'h1234_5678);
    check("st_wr_c3", {31'b0, mem_MemWrite}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("st_mem_written", mem[8'h10], 32'hDEAD_BEEF);

    // 6: reset during a fetch, then a fresh fetch with full latency
    i_req = 1'b1;
    step(); step();
    check("rm_rd_c2", {31'b0, mem_MemRead}, 32'd1);
    rst = 1'b0;
    step();
    check("rm_rd_c3", {31'b0, mem_MemRead}, 32'd0);
    check("rm_ready_c3", {31'b0, i_ready}, 32'd0);
    check("rm_rdata_cleared", i_rdata, 32'h0);
    rst = 1'b1;
    step();
    check("rm_new_rd_c1", {31'b0, mem_MemRead}, 32'd1);
    check("rm_new_ready_c1", {31'b0, i_ready}, 32'd0);
    step();
    check("rm_new_ready_c2", {31'b0, i_ready}, 32'd0);
    step();
    check("rm_new_ready_c3", {31'b0, i_ready}, 32'd1);
    check("rm_new_rdata_c3", i_rdata, 32'h8C01_0004);
    i_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
